// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: shared memory-bus widths, arbiter FSM states and port-select encoding
// Imported by the arbiter and by the fetch and exec stages that talk to it.
package core_mem_arbiter_pkg;
   localparam int unsigned MEM_ADDR_R = 64;
   localparam int unsigned MEM_DATA_R = 64;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_DRAIN  = 2'd3
   } arb_state_t;
   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } port_sel_t;
endpackage

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: shares one memory bus between fetch (I) and load/store (D), D-priority with bounded I starvation
// Ports: g_clk/g_resetn (sync, active-low); imem_* fetch read port; dmem_* LSU port;
//        mem_* shared bus (response valid in the mem_gnt cycle); *_rdata wired straight from mem_rdata.
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 3,
   parameter int unsigned MEM_ADDR_W = MEM_ADDR_R,
   parameter int unsigned MEM_DATA_W = MEM_DATA_R
) (
   input  logic                    g_clk,
   input  logic                    g_resetn,
   input  logic                    imem_req,
   input  logic [MEM_ADDR_W-1:0]   imem_addr,
   output logic                    imem_gnt,
   output logic                    imem_err,
   output logic [MEM_DATA_W-1:0]   imem_rdata,
   input  logic                    dmem_req,
   input  logic [MEM_ADDR_W-1:0]   dmem_addr,
   input  logic                    dmem_wen,
   input  logic [MEM_DATA_W/8-1:0] dmem_strb,
   input  logic [MEM_DATA_W-1:0]   dmem_wdata,
   output logic                    dmem_gnt,
   output logic                    dmem_err,
   output logic [MEM_DATA_W-1:0]   dmem_rdata,
   output logic                    mem_req,
   output logic [MEM_ADDR_W-1:0]   mem_addr,
   output logic                    mem_wen,
   output logic [MEM_DATA_W/8-1:0] mem_strb,
   output logic [MEM_DATA_W-1:0]   mem_wdata,
   input  logic                    mem_gnt,
   input  logic                    mem_err,
   input  logic [MEM_DATA_W-1:0]   mem_rdata
);
   localparam int unsigned SW = MEM_DATA_W / 8;
   localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   arb_state_t            state;
   logic [CW-1:0]         starve_cnt;
   logic [MEM_ADDR_W-1:0] hold_addr;
   logic                  hold_wen;
   logic [SW-1:0]         hold_strb;
   logic [MEM_DATA_W-1:0] hold_wdata;
   port_sel_t             sel;
   logic                  idle, any_req, starved, own_i, own_d;
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;
   // Once locked, the bus is driven from the hold register so requester changes cannot leak out.
   always_comb begin
      idle      = state == ST_IDLE;
      any_req   = imem_req | dmem_req;
      starved   = starve_cnt == CW'(STARVE_MAX);
      sel       = (dmem_req && !(starved && imem_req)) ? SEL_D : SEL_I;
      own_i     = idle ? (imem_req && sel == SEL_I) : state == ST_BUSY_I;
      own_d     = idle ? (dmem_req && sel == SEL_D) : state == ST_BUSY_D;
      mem_req   = g_resetn && (idle ? any_req : 1'b1);
      mem_addr  = !idle ? hold_addr  : sel == SEL_D ? dmem_addr  : imem_addr;
      mem_wen   = !idle ? hold_wen   : sel == SEL_D && dmem_wen;
      mem_strb  = !idle ? hold_strb  : sel == SEL_D ? dmem_strb  : '1;
      mem_wdata = !idle ? hold_wdata : sel == SEL_D ? dmem_wdata : '0;
      imem_gnt  = g_resetn && own_i && mem_gnt;
      dmem_gnt  = g_resetn && own_d && mem_gnt;
      imem_err  = imem_gnt && mem_err;
      dmem_err  = dmem_gnt && mem_err;
   end
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state      <= ST_IDLE;
         starve_cnt <= '0;
         hold_addr  <= '0;
         hold_wen   <= 1'b0;
         hold_strb  <= '0;
         hold_wdata <= '0;
      end else begin
         if (idle && any_req) begin
            hold_addr  <= mem_addr;
            hold_wen   <= mem_wen;
            hold_strb  <= mem_strb;
            hold_wdata <= mem_wdata;
         end
         // Drained responses are not grants, so they leave the counter alone.
         if (imem_gnt)
            starve_cnt <= '0;
         else if (dmem_gnt)
            starve_cnt <= !imem_req ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
         case (state)
            ST_IDLE:   if (any_req && !mem_gnt) state <= (sel == SEL_D) ? ST_BUSY_D : ST_BUSY_I;
            ST_BUSY_I: if (mem_gnt) state <= ST_IDLE; else if (!imem_req) state <= ST_DRAIN;
            ST_BUSY_D: if (mem_gnt) state <= ST_IDLE; else if (!dmem_req) state <= ST_DRAIN;
            ST_DRAIN:  if (mem_gnt) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed scoreboard bench for core_mem_arbiter
module tb_core_mem_arbiter;
   import core_mem_arbiter_pkg::*;
   logic        g_clk, g_resetn;
   logic        imem_req, imem_gnt, imem_err;
   logic [63:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_wen, dmem_gnt, dmem_err;
   logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [7:0]  dmem_strb, mem_strb;
   logic        mem_req, mem_wen, mem_gnt, mem_err;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   int n_vec = 0;
   int n_err = 0;
   typedef struct {
      logic        d;
      logic [63:0] addr;
      logic        err;
   } exp_t;
   exp_t q[$];
   core_mem_arbiter #(.STARVE_MAX(3), .MEM_ADDR_W(64), .MEM_DATA_W(64)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_err(imem_err), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
   );
   initial begin
      g_clk = 0;
      forever #5 g_clk = ~g_clk;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_gnt(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s observed=grant expected=empty-scoreboard", tag);
      end else begin
         e = q.pop_front();
         chk({tag, ".dgnt"}, 64'(dmem_gnt), 64'(e.d));
         chk({tag, ".ignt"}, 64'(imem_gnt), 64'(!e.d));
         chk({tag, ".addr"}, mem_addr, e.addr);
         chk({tag, ".err"}, 64'(e.d ? dmem_err : imem_err), 64'(e.err));
         chk({tag, ".err_other"}, 64'(e.d ? imem_err : dmem_err), 64'd0);
      end
   endtask
   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask
   task automatic quiet();
      imem_req = 0; dmem_req = 0; dmem_wen = 0; dmem_strb = 8'hFF;
      mem_gnt = 0; mem_err = 0;
   endtask
   initial begin
      g_resetn = 0; imem_req = 1; imem_addr = 64'h100; dmem_req = 1; dmem_addr = 64'h200;
      dmem_wen = 1; dmem_strb = 8'h0F; dmem_wdata = 64'h1234; mem_gnt = 1; mem_err = 0; mem_rdata = 64'h0;
      #1;
      chk("rst.mem_req", 64'(mem_req), 64'd0);
      chk("rst.dgnt", 64'(dmem_gnt), 64'd0);
      chk("rst.ignt", 64'(imem_gnt), 64'd0);
      tick();
      chk("rst.state", 64'(dut.state), 64'(ST_IDLE));
      chk("rst.cnt", 64'(dut.starve_cnt), 64'd0);
      chk("rst.hold", dut.hold_addr, 64'd0);
      g_resetn = 1; quiet();
      tick();
      // both request, memory grants immediately: D wins
      imem_req = 1; imem_addr = 64'h100; dmem_req = 1; dmem_addr = 64'h200; dmem_wen = 0;
      mem_gnt = 1; mem_rdata = 64'hCAFE_F00D_0000_0001;
      q.push_back('{1'b1, 64'h200, 1'b0});
      #1;
      check_gnt("both1");
      chk("both1.rdata", dmem_rdata, 64'hCAFE_F00D_0000_0001);
      chk("both1.mem_req", 64'(mem_req), 64'd1);
      tick();
      chk("both1.cnt", 64'(dut.starve_cnt), 64'd1);
      chk("both1.state", 64'(dut.state), 64'(ST_IDLE));
      for (int k = 0; k < 2; k++) begin
         q.push_back('{1'b1, 64'h200, 1'b0});
         #1;
         check_gnt("dstream");
         tick();
         chk("dstream.cnt", 64'(dut.starve_cnt), 64'(k + 2));
      end
      // starve counter saturated: I is forced to win
      q.push_back('{1'b0, 64'h100, 1'b0});
      #1;
      check_gnt("starve");
      chk("starve.wen", 64'(mem_wen), 64'd0);
      chk("starve.strb", 64'(mem_strb), 64'hFF);
      tick();
      chk("starve.cnt", 64'(dut.starve_cnt), 64'd0);
      quiet();
      // delayed store with fields changed after lock
      dmem_req = 1; dmem_addr = 64'h300; dmem_wen = 1; dmem_strb = 8'h0F; dmem_wdata = 64'hDEAD_BEEF;
      q.push_back('{1'b1, 64'h300, 1'b0});
      #1;
      chk("st0.mem_req", 64'(mem_req), 64'd1);
      chk("st0.dgnt", 64'(dmem_gnt), 64'd0);
      tick();
      chk("st.state", 64'(dut.state), 64'(ST_BUSY_D));
      dmem_wdata = 64'hFFFF_0000_1111_2222; dmem_strb = 8'hF0; dmem_addr = 64'h999; dmem_wen = 0;
      for (int c = 1; c < 3; c++) begin
         #1;
         chk("st.wdata", mem_wdata, 64'hDEAD_BEEF);
         chk("st.strb", 64'(mem_strb), 64'h0F);
         chk("st.wen", 64'(mem_wen), 64'd1);
         chk("st.addr", mem_addr, 64'h300);
         chk("st.dgnt", 64'(dmem_gnt), 64'd0);
         tick();
      end
      mem_gnt = 1;
      #1;
      check_gnt("st.gnt");
      chk("st.gnt_wdata", mem_wdata, 64'hDEAD_BEEF);
      tick();
      quiet();
      #1;
      chk("st.pulse", 64'(dmem_gnt), 64'd0);
      chk("st.idle", 64'(dut.state), 64'(ST_IDLE));
      chk("st.cnt", 64'(dut.starve_cnt), 64'd0);
      tick();
      // fetch withdrawn after lock: response drained
      imem_req = 1; imem_addr = 64'h1000;
      #1;
      chk("dr.addr0", mem_addr, 64'h1000);
      tick();
      imem_req = 0; imem_addr = 64'h2000;
      #1;
      chk("dr.mem_req1", 64'(mem_req), 64'd1);
      chk("dr.ignt1", 64'(imem_gnt), 64'd0);
      tick();
      chk("dr.state", 64'(dut.state), 64'(ST_DRAIN));
      chk("dr.addr", mem_addr, 64'h1000);
      chk("dr.mem_req", 64'(mem_req), 64'd1);
      tick();
      mem_gnt = 1; mem_err = 1;
      #1;
      chk("dr.ignt", 64'(imem_gnt), 64'd0);
      chk("dr.ierr", 64'(imem_err), 64'd0);
      chk("dr.dgnt", 64'(dmem_gnt), 64'd0);
      tick();
      quiet();
      #1;
      chk("dr.idle", 64'(dut.state), 64'(ST_IDLE));
      chk("dr.req_off", 64'(mem_req), 64'd0);
      tick();
      // D load completes with error while I waits
      imem_req = 1; imem_addr = 64'h100; dmem_req = 1; dmem_addr = 64'h400; dmem_wen = 0;
      mem_gnt = 1; mem_err = 1;
      q.push_back('{1'b1, 64'h400, 1'b1});
      #1;
      check_gnt("derr");
      tick();
      chk("derr.cnt", 64'(dut.starve_cnt), 64'd1);
      quiet();
      // withdrawal in the grant cycle still completes
      dmem_req = 1; dmem_addr = 64'h600;
      q.push_back('{1'b1, 64'h600, 1'b0});
      tick();
      dmem_req = 0; dmem_addr = 64'h777; mem_gnt = 1;
      #1;
      check_gnt("wdgnt");
      tick();
      quiet();
      #1;
      chk("wdgnt.idle", 64'(dut.state), 64'(ST_IDLE));
      chk("wdgnt.cnt", 64'(dut.starve_cnt), 64'd0);
      // reset in the middle of a D transaction
      dmem_req = 1; dmem_addr = 64'h500;
      tick();
      chk("rbusy.state", 64'(dut.state), 64'(ST_BUSY_D));
      g_resetn = 0; mem_gnt = 1;
      #1;
      chk("rbusy.mem_req", 64'(mem_req), 64'd0);
      chk("rbusy.dgnt", 64'(dmem_gnt), 64'd0);
      tick();
      chk("rbusy.idle", 64'(dut.state), 64'(ST_IDLE));
      chk("rbusy.hold", dut.hold_addr, 64'd0);
      g_resetn = 1; quiet();
      tick();
      chk("sb.empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
